// File: rtl/nand_logic_unit_pkg.sv
// Shared definitions for the NAND-only logic unit: op codes, BIST states and
// the golden truth table that BIST sweeps.
package nand_logic_pkg;

  localparam logic [2:0] OP_NAND = 3'd0;
  localparam logic [2:0] OP_AND  = 3'd1;
  localparam logic [2:0] OP_OR   = 3'd2;
  localparam logic [2:0] OP_NOR  = 3'd3;
  localparam logic [2:0] OP_XOR  = 3'd4;
  localparam logic [2:0] OP_XNOR = 3'd5;
  localparam logic [2:0] OP_NOTA = 3'd6;
  localparam logic [2:0] OP_BUF  = 3'd7;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_DRAIN = 2'd1,
    ST_RUN   = 2'd2,
    ST_DONE  = 2'd3
  } bist_state_e;

  // Row index is {a,b}; bit k is the expected output for that input pair.
  localparam logic [3:0] GOLDEN_TT [8] = '{
    4'b0111,  // NAND
    4'b1000,  // AND
    4'b1110,  // OR
    4'b0001,  // NOR
    4'b0110,  // XOR
    4'b1001,  // XNOR
    4'b0011,  // NOT a
    4'b1100   // BUF a
  };

endpackage

// File: rtl/nand_logic_unit_if.sv
// Operand/result handshake bundle for nand_logic_unit.
interface nand_logic_unit_if #(parameter int WIDTH = 8);

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [2:0]       op;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] y;

  modport master (
    output in_valid, a, b, op, out_ready,
    input  in_ready, out_valid, y
  );

  modport slave (
    input  in_valid, a, b, op, out_ready,
    output in_ready, out_valid, y
  );

endinterface

// File: rtl/nand_logic_unit_datapath.sv
// NAND primitive and the combinational function block built solely from it;
// op only steers which NAND network drives the result.
module nand_cell #(parameter int WIDTH = 8) (
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  output logic [WIDTH-1:0] y_o
);
  assign y_o = ~(a_i & b_i);
endmodule

module nand_datapath import nand_logic_pkg::*; #(parameter int WIDTH = 8) (
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic [2:0]       op_i,
  output logic [WIDTH-1:0] y_o
);
  logic [WIDTH-1:0] n_ab, n_a, n_b, and_w, or_w, nor_w;
  logic [WIDTH-1:0] t_a, t_b, xor_w, xnor_w, buf_w;

  nand_cell #(.WIDTH(WIDTH)) u_nab  (.a_i(a_i),   .b_i(b_i),   .y_o(n_ab));
  nand_cell #(.WIDTH(WIDTH)) u_na   (.a_i(a_i),   .b_i(a_i),   .y_o(n_a));
  nand_cell #(.WIDTH(WIDTH)) u_nb   (.a_i(b_i),   .b_i(b_i),   .y_o(n_b));
  nand_cell #(.WIDTH(WIDTH)) u_and  (.a_i(n_ab),  .b_i(n_ab),  .y_o(and_w));
  nand_cell #(.WIDTH(WIDTH)) u_or   (.a_i(n_a),   .b_i(n_b),   .y_o(or_w));
  nand_cell #(.WIDTH(WIDTH)) u_nor  (.a_i(or_w),  .b_i(or_w),  .y_o(nor_w));
  // Classic four-NAND XOR sharing the n_ab term.
  nand_cell #(.WIDTH(WIDTH)) u_ta   (.a_i(a_i),   .b_i(n_ab),  .y_o(t_a));
  nand_cell #(.WIDTH(WIDTH)) u_tb   (.a_i(b_i),   .b_i(n_ab),  .y_o(t_b));
  nand_cell #(.WIDTH(WIDTH)) u_xor  (.a_i(t_a),   .b_i(t_b),   .y_o(xor_w));
  nand_cell #(.WIDTH(WIDTH)) u_xnor (.a_i(xor_w), .b_i(xor_w), .y_o(xnor_w));
  nand_cell #(.WIDTH(WIDTH)) u_buf  (.a_i(n_a),   .b_i(n_a),   .y_o(buf_w));

  always_comb begin
    y_o = n_ab;
    case (op_i)
      OP_NAND: y_o = n_ab;
      OP_AND:  y_o = and_w;
      OP_OR:   y_o = or_w;
      OP_NOR:  y_o = nor_w;
      OP_XOR:  y_o = xor_w;
      OP_XNOR: y_o = xnor_w;
      OP_NOTA: y_o = n_a;
      OP_BUF:  y_o = buf_w;
      default: y_o = n_ab;
    endcase
  end
endmodule

// File: rtl/nand_logic_unit.sv
// Registered NAND-only logic unit with a single-entry output stage and a
// truth-table BIST sequencer sharing the datapath.
//
// state    | meaning
// ST_IDLE  | normal operation, operands accepted
// ST_DRAIN | BIST requested, waiting for the pending result to be taken
// ST_RUN   | sweeping idx 0..31 through the datapath, collecting err
// ST_DONE  | publish bist_done pulse and bist_pass, then back to idle
module nand_logic_unit import nand_logic_pkg::*; #(parameter int WIDTH = 8) (
  input  logic              clk,
  input  logic              rst_n,
  nand_logic_unit_if.slave  bus,
  input  logic              bist_start_i,
  output logic              bist_busy_o,
  output logic              bist_done_o,
  output logic              bist_pass_o
);
  bist_state_e      state_q;
  logic [4:0]       idx_q;
  logic             err_q, busy_q, done_q, pass_q;
  logic [WIDTH-1:0] y_q, y_d;
  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] dp_a, dp_b, dp_y;
  logic [2:0]       dp_op;
  logic             accept, tt_bit, run_mismatch;

  assign bus.in_ready  = (state_q == ST_IDLE) && (!out_valid_q || bus.out_ready);
  assign accept        = bus.in_valid && bus.in_ready;
  assign bus.out_valid = out_valid_q;
  assign bus.y         = y_q;
  assign bist_busy_o   = busy_q;
  assign bist_done_o   = done_q;
  assign bist_pass_o   = pass_q;

  // The datapath is shared: BIST owns its inputs while running, never y.
  always_comb begin
    dp_op = bus.op;
    dp_a  = bus.a;
    dp_b  = bus.b;
    if (state_q == ST_RUN) begin
      dp_op = idx_q[4:2];
      dp_a  = {WIDTH{idx_q[1]}};
      dp_b  = {WIDTH{idx_q[0]}};
    end
  end

  nand_datapath #(.WIDTH(WIDTH)) u_dp (.a_i(dp_a), .b_i(dp_b), .op_i(dp_op), .y_o(dp_y));

  assign tt_bit       = GOLDEN_TT[dp_op][idx_q[1:0]];
  assign run_mismatch = (dp_y != {WIDTH{tt_bit}});

  always_comb begin
    y_d         = y_q;
    out_valid_d = out_valid_q;
    if (accept) begin
      y_d         = dp_y;
      out_valid_d = 1'b1;
    end else if (bus.out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      y_q         <= '0;
      out_valid_q <= 1'b0;
    end else begin
      y_q         <= y_d;
      out_valid_q <= out_valid_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      idx_q   <= '0;
      err_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      pass_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (bist_start_i) begin
            busy_q <= 1'b1;
            // An operand accepted in this same cycle also counts as pending.
            if (out_valid_q || accept) begin
              state_q <= ST_DRAIN;
            end else begin
              state_q <= ST_RUN;
              idx_q   <= '0;
              err_q   <= 1'b0;
              pass_q  <= 1'b0;
            end
          end
        end
        ST_DRAIN: begin
          if (!out_valid_q || bus.out_ready) begin
            state_q <= ST_RUN;
            idx_q   <= '0;
            err_q   <= 1'b0;
            pass_q  <= 1'b0;
          end
        end
        ST_RUN: begin
          err_q <= err_q | run_mismatch;
          idx_q <= idx_q + 5'd1;
          if (idx_q == 5'd31) begin
            state_q <= ST_DONE;
            busy_q  <= 1'b0;
          end
        end
        ST_DONE: begin
          done_q  <= 1'b1;
          pass_q  <= !err_q;
          err_q   <= 1'b0;
          state_q <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_nand_logic_unit.sv
// Scoreboard bench for nand_logic_unit: directed operand vectors with
// hand-computed results, backpressure, streaming and BIST scenarios.
module tb_nand_logic_unit;
  logic clk, rst_n;
  logic bist_start, bist_busy, bist_done, bist_pass;
  int   errors = 0;
  int   checks = 0;
  logic [7:0] exp_q[$];

  nand_logic_unit_if #(.WIDTH(8)) bus ();

  nand_logic_unit #(.WIDTH(8)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .bus          (bus),
    .bist_start_i (bist_start),
    .bist_busy_o  (bist_busy),
    .bist_done_o  (bist_done),
    .bist_pass_o  (bist_pass)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic [2:0] op;
    logic [7:0] exp;
  } vec_t;

  vec_t stream_tab[16] = '{
    '{8'h55, 8'hAA, 3'd0, 8'hFF}, '{8'h55, 8'hAA, 3'd1, 8'h00},
    '{8'h55, 8'hAA, 3'd2, 8'hFF}, '{8'h55, 8'hAA, 3'd3, 8'h00},
    '{8'h55, 8'hAA, 3'd4, 8'hFF}, '{8'h55, 8'hAA, 3'd5, 8'h00},
    '{8'h55, 8'hAA, 3'd6, 8'hAA}, '{8'h55, 8'hAA, 3'd7, 8'h55},
    '{8'hFF, 8'h0F, 3'd0, 8'hF0}, '{8'hFF, 8'h0F, 3'd1, 8'h0F},
    '{8'h3C, 8'h0F, 3'd2, 8'h3F}, '{8'h3C, 8'h0F, 3'd3, 8'hC0},
    '{8'h3C, 8'h0F, 3'd4, 8'h33}, '{8'h3C, 8'h0F, 3'd5, 8'hCC},
    '{8'h81, 8'h7E, 3'd6, 8'h7E}, '{8'h81, 8'h7E, 3'd7, 8'h81}
  };

  vec_t dir_tab[4] = '{
    '{8'hF0, 8'hCC, 3'd2, 8'hFC}, '{8'hF0, 8'hCC, 3'd4, 8'h3C},
    '{8'hF0, 8'hCC, 3'd0, 8'h3F}, '{8'hF0, 8'hCC, 3'd6, 8'h0F}
  };

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: a result is consumed on the edge following a negedge that sees
  // out_valid && out_ready; inputs only change just after posedge.
  initial begin
    forever begin
      @(negedge clk);
      if (rst_n && bus.out_valid && bus.out_ready) begin
        if (exp_q.size() == 0) begin
          check("unexpected_result", {24'd0, bus.y}, 32'hDEAD);
        end else begin
          check("result_y", {24'd0, bus.y}, {24'd0, exp_q.pop_front()});
        end
      end
    end
  end

  // Entered at posedge+1; returns at posedge+1 right after the accepting edge.
  task automatic drive(input logic [7:0] a, input logic [7:0] b, input logic [2:0] op,
                       input logic [7:0] exp);
    int n;
    n = 0;
    bus.in_valid = 1'b1;
    bus.a        = a;
    bus.b        = b;
    bus.op       = op;
    #1;
    while (!bus.in_ready && n < 50) begin
      @(posedge clk); #2;
      n++;
    end
    if (!bus.in_ready) begin
      check("accept_timeout", 32'd0, 32'd1);
      bus.in_valid = 1'b0;
      @(posedge clk); #1;
    end else begin
      exp_q.push_back(exp);
      @(posedge clk); #1;
      bus.in_valid = 1'b0;
    end
  endtask

  task automatic pulse_start();
    bist_start = 1'b1;
    @(posedge clk); #1;
    bist_start = 1'b0;
  endtask

  task automatic wait_done(input string tag);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 60 && !seen; i++) begin
      @(posedge clk); #1;
      if (bist_done) seen = 1'b1;
    end
    check({tag, "_done_seen"}, {31'd0, seen}, 32'd1);
    check({tag, "_pass"}, {31'd0, bist_pass}, 32'd1);
  endtask

  initial begin
    bit saw_done;
    rst_n         = 1'b0;
    bist_start    = 1'b0;
    bus.in_valid  = 1'b0;
    bus.a         = '0;
    bus.b         = '0;
    bus.op        = '0;
    bus.out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;

    check("rst_in_ready",  {31'd0, bus.in_ready},  32'd1);
    check("rst_out_valid", {31'd0, bus.out_valid}, 32'd0);
    check("rst_y",         {24'd0, bus.y},         32'h00);
    check("rst_pass",      {31'd0, bist_pass},     32'd0);
    check("rst_busy",      {31'd0, bist_busy},     32'd0);
    check("rst_done",      {31'd0, bist_done},     32'd0);

    // Back-to-back directed ops, one-cycle latency.
    bus.out_ready = 1'b1;
    foreach (dir_tab[i]) begin
      drive(dir_tab[i].a, dir_tab[i].b, dir_tab[i].op, dir_tab[i].exp);
      check("latency_out_valid", {31'd0, bus.out_valid}, 32'd1);
    end
    @(posedge clk); #1;

    // Backpressure: first result parked, second operand must stall.
    bus.out_ready = 1'b0;
    drive(8'hF0, 8'hCC, 3'd5, 8'hC3);
    bus.in_valid = 1'b1;
    bus.a = 8'h0F; bus.b = 8'h33; bus.op = 3'd3;
    for (int i = 0; i < 5; i++) begin
      #1;
      check("bp_in_ready", {31'd0, bus.in_ready}, 32'd0);
      check("bp_y_stable", {24'd0, bus.y}, 32'hC3);
      @(posedge clk); #1;
    end
    bus.out_ready = 1'b1;
    drive(8'h0F, 8'h33, 3'd3, 8'hC0);
    @(posedge clk); #1;

    // Streaming: one accept per cycle for 16 cycles.
    foreach (stream_tab[i]) begin
      drive(stream_tab[i].a, stream_tab[i].b, stream_tab[i].op, stream_tab[i].exp);
      check("stream_out_valid", {31'd0, bus.out_valid}, 32'd1);
    end
    repeat (2) @(posedge clk);
    #1;

    // BIST from idle with no pending result.
    pulse_start();
    for (int i = 0; i < 32; i++) begin
      check("bist_busy",     {31'd0, bist_busy},    32'd1);
      check("bist_in_ready", {31'd0, bus.in_ready}, 32'd0);
      check("bist_no_done",  {31'd0, bist_done},    32'd0);
      @(posedge clk); #1;
    end
    check("bist_busy_end", {31'd0, bist_busy}, 32'd0);
    check("bist_done_early", {31'd0, bist_done}, 32'd0);
    @(posedge clk); #1;
    check("bist_done_33", {31'd0, bist_done}, 32'd1);
    check("bist_pass_idle", {31'd0, bist_pass}, 32'd1);
    @(posedge clk); #1;
    check("bist_done_pulse", {31'd0, bist_done}, 32'd0);
    check("bist_pass_held", {31'd0, bist_pass}, 32'd1);

    // Pending result then BIST: wait in DRAIN with y held.
    bus.out_ready = 1'b0;
    drive(8'hF0, 8'hCC, 3'd1, 8'hC0);
    pulse_start();
    for (int i = 0; i < 4; i++) begin
      check("drain_busy",     {31'd0, bist_busy},     32'd1);
      check("drain_in_ready", {31'd0, bus.in_ready},  32'd0);
      check("drain_y_held",   {24'd0, bus.y},         32'hC0);
      check("drain_valid",    {31'd0, bus.out_valid}, 32'd1);
      @(posedge clk); #1;
    end
    bus.out_ready = 1'b1;
    wait_done("drain");
    @(posedge clk); #1;

    // Reset in the middle of a run aborts it.
    pulse_start();
    check("run_pass_cleared", {31'd0, bist_pass}, 32'd0);
    repeat (10) @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    check("abort_busy", {31'd0, bist_busy}, 32'd0);
    check("abort_pass", {31'd0, bist_pass}, 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    saw_done = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      if (bist_done) saw_done = 1'b1;
    end
    check("abort_no_done", {31'd0, saw_done}, 32'd0);
    pulse_start();
    wait_done("fresh");

    repeat (2) @(posedge clk);
    #1;
    check("scoreboard_empty", exp_q.size(), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/nand_logic_unit.md
Name: nand_logic_unit

Overview:
- Parametrised, registered logic unit that computes one of eight bitwise two-input functions over WIDTH-bit operands.
- Every function is built only from 2-input NAND cells.
- Input side uses a valid/ready handshake; the output is a single-entry register with its own valid/ready handshake.
- A built-in self-test (BIST) sequencer sweeps the full truth table of every op and reports pass/fail.
- Used as the team's universal gate datapath, replacing single-function NAND gate constructions.

Parameters:
- WIDTH, 8, operand/result width in bits (>=1).

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  operand/op valid.
- in_ready  out  1  unit can accept operands this cycle.
- a  in  WIDTH  operand A.
- b  in  WIDTH  operand B.
- op  in  3  function select (see Behaviour).
- out_valid  out  1  y holds a result.
- out_ready  in  1  consumer takes y this cycle.
- y  out  WIDTH  registered result.
- bist_start  in  1  single-cycle request to run BIST.
- bist_busy  out  1  BIST in progress (includes waiting to drain).
- bist_done  out  1  one-cycle pulse when BIST finishes.
- bist_pass  out  1  result of the last BIST; held until next start or reset.

Behaviour:
- Reset (async assert, sync release) sets: y=0, out_valid=0, bist_busy=0, bist_done=0, bist_pass=0, FSM=IDLE.
- Op encoding:
  - 0 NAND, 1 AND, 2 OR, 3 NOR, 4 XOR, 5 XNOR, 6 NOT a, 7 BUF a.
  - Each op is implemented purely from nand_cell instances, bitwise across WIDTH.
- Output register:
  - in_ready = (FSM==IDLE) && (!out_valid || out_ready).
  - Accept occurs when in_valid && in_ready.
  - On accept: y <= f(a,b,op) and out_valid <= 1 on the next edge. Latency is 1 cycle.
  - Else if out_ready: out_valid <= 0 and y holds its value.
  - Accept and drain in the same cycle gives a new result with out_valid remaining 1, so throughput is 1 result/cycle.
  - While out_valid=1 && out_ready=0, y is stable.
- BIST FSM: IDLE -> DRAIN -> RUN -> DONE -> IDLE.
  - IDLE:
    - bist_start=1 goes to RUN if out_valid=0, otherwise to DRAIN.
    - bist_start is ignored outside IDLE.
  - DRAIN: stay until the pending result is consumed (out_valid falls), then go to RUN. in_ready=0.
  - RUN:
    - A 5-bit counter idx runs 0..31.
    - Drive op=idx[4:2], a={WIDTH{idx[1]}}, b={WIDTH{idx[0]}} into the NAND datapath (not into y).
    - Compare all WIDTH bits against GOLDEN_TT[op][idx[1:0]].
    - Any mismatch sets a sticky err flag.
    - After idx=31, go to DONE.
  - DONE: for one cycle, bist_done=1 and bist_pass=!err. Then go to IDLE and clear err.
- bist_busy=1 in DRAIN and RUN.
- in_ready=0 and out_valid is not set by BIST in any non-IDLE state; y is untouched by BIST.
- Timing from start in IDLE with out_valid=0: bist_done is asserted on the 33rd edge after the edge that samples bist_start.
- bist_pass is cleared to 0 on entering RUN.
- Reset mid-BIST aborts the run: bist_pass=0, no done pulse.

Decomposition:
- Package nand_logic_pkg contains:
  - op localparams (OP_NAND..OP_BUF);
  - the FSM state enum;
  - GOLDEN_TT, an 8x4-bit constant holding the expected truth table per op.
- Sub-module nand_cell (WIDTH-bit, 2-input NAND) is the only logic primitive.
- The datapath is a combinational function block of nand_cell instances.

Test Plan:
- Reset → in_ready=1, out_valid=0, y=8'h00, bist_pass=0, bist_busy=0.
- a=8'hF0, b=8'hCC, applied on consecutive cycles with out_ready=1:
  - op=2 → y=8'hFC;
  - op=4 → y=8'h3C;
  - op=0 → y=8'h3F;
  - op=6 → y=8'h0F;
  - each result appears 1 cycle after accept, with out_valid held high.
- Backpressure: out_ready=0 after one accept → in_ready=0, y stable for 5 cycles, second operand stalls. When out_ready=1, the second result appears on the next edge with no loss or duplication.
- Streaming: in_valid=1 and out_ready=1 for 16 cycles with random a/b/op → 16 results, each matching the model, one per cycle.
- BIST from idle: pulse bist_start → bist_busy=1 for 32 cycles, bist_done pulse on cycle 33, bist_pass=1, in_ready=0 throughout.
- Pending result plus BIST:
  - out_valid=1 and out_ready=0 when bist_start pulses → FSM stays in DRAIN and y is held.
  - When out_ready=1, RUN starts and completes with pass=1.
  - Separate check: assert rst_n=0 at RUN idx=10 → busy=0, pass=0, no done pulse. A fresh start then passes.
